snapshot_mem_bridge: RTL
========================

# snapshot_mem_bridge

Parametrised snapshot bridge between a narrow reg_native_if upstream (regslv side) and a wide external memory reg_native_if downstream. Collects RATIO = MEM_DATA_WIDTH/DATA_WIDTH bus words into a write snapshot and commits them as one atomic wide write. Captures a whole memory entry into a read snapshot so that multi-word reads are coherent. Replaces per-design hand-built snapshot logic wherever an external memory is wider than the bus.

## Interface
- ADDR_WIDTH, 64, upstream address width (block-relative byte address)
- DATA_WIDTH, 32, bus data width
- MEM_ADDR_WIDTH, 1, memory entry index width; MEM_ENTRY = 2**MEM_ADDR_WIDTH
- MEM_DATA_WIDTH, 128, memory data width; must equal DATA_WIDTH × RATIO, with RATIO a power of two ≥ 2
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_vld / req_rdy  in / out  1  upstream request handshake
- wr_en, rd_en  in  1  upstream access type
- addr  in  ADDR_WIDTH  byte address
- wr_data  in  DATA_WIDTH  write word
- ack_vld / ack_rdy  out / in  1  upstream response handshake
- rd_data  out  DATA_WIDTH  read word, registered
- mem_req_vld / mem_req_rdy  out / in  1  downstream request handshake
- mem_wr_en, mem_rd_en  out  1  downstream access type
- mem_addr  out  MEM_ADDR_WIDTH  entry index
- mem_wr_data  out  MEM_DATA_WIDTH  wide write data
- mem_rd_data  in  MEM_DATA_WIDTH  wide read data, valid with mem_ack_vld
- mem_ack_vld / mem_ack_rdy  in / out  1  downstream response handshake

## Operation
- Address decode, with BOFF = log2(DATA_WIDTH/8) and WB = log2(RATIO):
  - word index k = addr[BOFF +: WB]
  - entry e = addr[BOFF+WB +: MEM_ADDR_WIDTH]
  - higher address bits are ignored.
- Word k occupies mem bits [DATA_WIDTH·k +: DATA_WIDTH]. Word 0 is the trigger word.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, ACK.
  - IDLE: req_rdy=1. A request is accepted on req_vld & req_rdy.
  - ACK: hold ack_vld=1 until ack_rdy, then go to IDLE.
- Write, k≠0:
  - wbuf[k] ← wr_data; wmask[k] ← 1.
  - IDLE→ACK. No memory access.
- Write, k=0:
  - The commit word is {wbuf[RATIO-1:1], wr_data}.
  - IDLE→WR_REQ→WR_WAIT→ACK.
  - After the memory ack, wmask is cleared. wbuf contents are retained.
  - If the read snapshot is valid for entry e, rd_valid is cleared.
- Read, k=0:
  - Always fetches: IDLE→RD_REQ→RD_WAIT→ACK.
  - rbuf ← mem_rd_data, rtag ← e, rd_valid ← 1.
  - rd_data ← word 0.
- Read, k≠0:
  - If rd_valid & rtag==e: rd_data ← rbuf[k], IDLE→ACK, no memory access.
  - Otherwise: fetch as for k=0, then return word k.
- Both wr_en and rd_en set: treated as a write.
- Neither set: ack with rd_data=0 and no side effect.
- The write and read snapshots are independent. Interleaved reads never disturb pending write words.

## Timing
- Reset values:
  - req_rdy=1 (IDLE)
  - ack_vld=0, rd_data=0
  - mem_req_vld=0, mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wr_data=0, mem_ack_rdy=0
  - wbuf=0, wmask=0, rbuf=0, rd_valid=0, rtag=0
- Buffered access (write k≠0, read snapshot hit): ack_vld rises in the cycle after acceptance.
- Memory access:
  - mem_req_vld rises the cycle after acceptance and holds with stable addr/data until mem_req_rdy.
  - mem_ack_rdy=1 only in RD_WAIT/WR_WAIT.
  - ack_vld rises the cycle after mem_ack_vld & mem_ack_rdy.
  - Minimum latency is 3 cycles with a zero-wait memory.
- req_rdy=0 in every non-IDLE state. A new request can be accepted in the cycle after ack_vld & ack_rdy.
- rd_data is stable while ack_vld is high.
- Reset asserted mid-operation:
  - All state returns to reset values immediately.
  - A pending memory transaction is abandoned.
  - Partially written snapshots are lost.

## Configuration
- SNAPSHOT_RMW_EN defined:
  - A trigger write with any wmask[k]=0 (k≠0) first performs RD_REQ/RD_WAIT on entry e.
  - The commit word takes memory bits for unmasked words and wbuf for masked words.
  - Sequence: IDLE→RD_REQ→RD_WAIT→WR_REQ→WR_WAIT→ACK.
  - If wmask is all ones, the read is skipped.
- SNAPSHOT_RMW_EN undefined:
  - No pre-read. Unwritten words commit whatever wbuf holds (zero after reset).

## Test plan
- RATIO=4, entry 0 preset 0xAAAA…AA; write 0xFFFFFFFF to words 3,2,1 → mem[0] unchanged, no mem_req_vld; then write word 0 = 0xFFFFFFFF → mem[0] = all ones after one memory write.
- After reset, mem[1]=0xAAAA…AA; write word 1 = 0x12345678, then word 0 = 0 → with SNAPSHOT_RMW_EN mem[1]=0xAAAAAAAA_AAAAAAAA_12345678_00000000; without → 0x00000000_00000000_12345678_00000000.
- mem[1]=0x33333333_22222222_11111111_00000000; read word 0 → 0x00000000; backdoor mem[1]=0xAAAA…AA; read words 1..3 → 0x11111111, 0x22222222, 0x33333333; exactly one mem_req_vld seen.
- After reset, read word 2 of entry 0 with no prior word-0 read → memory fetch occurs and returns the current mem[0] bits [95:64].
- Hold ack_rdy=0 for 5 cycles on a snapshot-hit read → ack_vld and rd_data stable, req_rdy=0, no new accept; also stall mem_req_rdy 4 cycles → mem_addr/mem_wr_data stable.
- Assert rstn low during RD_WAIT → all outputs at reset values next edge; the next word-k≠0 read refetches (rd_valid=0).

Source files
------------

// File: rtl/snapshot_mem_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : snapshot_mem_bridge
// Description : Narrow-bus to wide-memory snapshot bridge with atomic wide
//               commits and coherent multi-word reads.
//               Optional macro SNAPSHOT_RMW_EN: pre-read merge of unwritten
//               words on a trigger write.
// Revision    : 1.0 - initial release
// ============================================================================
module snapshot_mem_bridge #(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 1,
   parameter int MEM_DATA_WIDTH = 128
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      req_vld,
   output logic                      req_rdy,
   input  logic                      wr_en,
   input  logic                      rd_en,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   output logic                      ack_vld,
   input  logic                      ack_rdy,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      mem_req_vld,
   input  logic                      mem_req_rdy,
   output logic                      mem_wr_en,
   output logic                      mem_rd_en,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
   input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
   input  logic                      mem_ack_vld,
   output logic                      mem_ack_rdy
);

   localparam int RATIO = MEM_DATA_WIDTH / DATA_WIDTH;
   localparam int BOFF  = $clog2(DATA_WIDTH / 8);
   localparam int WB    = $clog2(RATIO);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR_REQ  = 3'd3,
      S_WR_WAIT = 3'd4,
      S_ACK     = 3'd5
   } state_t;

   state_t                            r_state;
   logic [WB-1:0]                     r_k;
   logic [MEM_ADDR_WIDTH-1:0]         r_e;
   logic [MEM_DATA_WIDTH-1:DATA_WIDTH] r_wbuf;
   logic [RATIO-1:1]                  r_wmask;
   logic [MEM_DATA_WIDTH-1:0]         r_rbuf;
   logic                              r_rd_valid;
   logic [MEM_ADDR_WIDTH-1:0]         r_rtag;
   logic                              r_rmw;
   logic [DATA_WIDTH-1:0]             r_word0;

   logic [WB-1:0]                     w_k;
   logic [MEM_ADDR_WIDTH-1:0]         w_e;
   logic                              w_accept;
   logic                              w_hit;
   logic                              w_pre_read;
   logic [MEM_DATA_WIDTH-1:0]         w_commit;
   logic [MEM_DATA_WIDTH-1:0]         w_merge;

   assign w_k      = addr[BOFF +: WB];
   assign w_e      = addr[BOFF+WB +: MEM_ADDR_WIDTH];
   assign w_accept = req_vld & req_rdy;
   assign w_hit    = (w_k != '0) & r_rd_valid & (r_rtag == w_e);
   assign w_commit = {r_wbuf, wr_data};

`ifdef SNAPSHOT_RMW_EN
   assign w_pre_read = ~&r_wmask;
`else
   assign w_pre_read = 1'b0;
`endif

   // Merge for the pre-read path: written words from wbuf, the rest from memory
   assign w_merge[DATA_WIDTH-1:0] = r_word0;
   for (genvar gi = 1; gi < RATIO; gi++) begin : g_merge
      assign w_merge[DATA_WIDTH*gi +: DATA_WIDTH] = r_wmask[gi]
         ? r_wbuf[DATA_WIDTH*gi +: DATA_WIDTH]
         : mem_rd_data[DATA_WIDTH*gi +: DATA_WIDTH];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         req_rdy     <= 1'b1;
         ack_vld     <= 1'b0;
         rd_data     <= '0;
         mem_req_vld <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
         mem_ack_rdy <= 1'b0;
         r_k         <= '0;
         r_e         <= '0;
         r_wbuf      <= '0;
         r_wmask     <= '0;
         r_rbuf      <= '0;
         r_rd_valid  <= 1'b0;
         r_rtag      <= '0;
         r_rmw       <= 1'b0;
         r_word0     <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               req_rdy  <= 1'b0;
               r_k      <= w_k;
               r_e      <= w_e;
               mem_addr <= w_e;
               if (wr_en) begin
                  if (w_k != '0) begin
                     r_wbuf[DATA_WIDTH*w_k +: DATA_WIDTH] <= wr_data;
                     r_wmask[w_k] <= 1'b1;
                     rd_data      <= '0;
                     ack_vld      <= 1'b1;
                     r_state      <= S_ACK;
                  end else if (w_pre_read) begin
                     r_word0     <= wr_data;
                     r_rmw       <= 1'b1;
                     mem_rd_en   <= 1'b1;
                     mem_req_vld <= 1'b1;
                     r_state     <= S_RD_REQ;
                  end else begin
                     mem_wr_data <= w_commit;
                     mem_wr_en   <= 1'b1;
                     mem_req_vld <= 1'b1;
                     r_state     <= S_WR_REQ;
                  end
               end else if (rd_en) begin
                  if (w_hit) begin
                     rd_data <= r_rbuf[DATA_WIDTH*w_k +: DATA_WIDTH];
                     ack_vld <= 1'b1;
                     r_state <= S_ACK;
                  end else begin
                     mem_rd_en   <= 1'b1;
                     mem_req_vld <= 1'b1;
                     r_state     <= S_RD_REQ;
                  end
               end else begin
                  rd_data <= '0;
                  ack_vld <= 1'b1;
                  r_state <= S_ACK;
               end
            end
            S_RD_REQ: if (mem_req_rdy) begin
               mem_req_vld <= 1'b0;
               mem_rd_en   <= 1'b0;
               mem_ack_rdy <= 1'b1;
               r_state     <= S_RD_WAIT;
            end
            S_RD_WAIT: if (mem_ack_vld) begin
               mem_ack_rdy <= 1'b0;
               if (r_rmw) begin
                  // Pre-read for a trigger write does not touch the read snapshot
                  r_rmw       <= 1'b0;
                  mem_wr_data <= w_merge;
                  mem_wr_en   <= 1'b1;
                  mem_req_vld <= 1'b1;
                  r_state     <= S_WR_REQ;
               end else begin
                  r_rbuf     <= mem_rd_data;
                  r_rtag     <= r_e;
                  r_rd_valid <= 1'b1;
                  rd_data    <= mem_rd_data[DATA_WIDTH*r_k +: DATA_WIDTH];
                  ack_vld    <= 1'b1;
                  r_state    <= S_ACK;
               end
            end
            S_WR_REQ: if (mem_req_rdy) begin
               mem_req_vld <= 1'b0;
               mem_wr_en   <= 1'b0;
               mem_ack_rdy <= 1'b1;
               r_state     <= S_WR_WAIT;
            end
            S_WR_WAIT: if (mem_ack_vld) begin
               mem_ack_rdy <= 1'b0;
               r_wmask     <= '0;
               if (r_rd_valid && (r_rtag == r_e))
                  r_rd_valid <= 1'b0;
               rd_data     <= '0;
               ack_vld     <= 1'b1;
               r_state     <= S_ACK;
            end
            S_ACK: if (ack_rdy) begin
               ack_vld <= 1'b0;
               req_rdy <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               req_rdy <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
